// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Byte-stream link between the I/O controller and the UART transmitter.
//   master : the controller. It drives din/wr and observes the status and line.
//   slave  : the transmitter. It accepts din/wr and drives full/empty/busy/ovf/tx.
// Signals
//   din   [7:0]  byte to transmit
//   wr           write strobe, accepted when full=0
//   full         FIFO holds FIFO_DEPTH bytes
//   empty        FIFO holds 0 bytes
//   busy         serializer is not idle
//   ovf          sticky overflow, a write was attempted while full
//   tx           serial line, idle high
interface uart_tx_fifo_if;
  logic [7:0] din;
  logic       wr;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;
  logic       tx;

  modport master (output din, wr, input full, empty, busy, ovf, tx);
  modport slave  (input din, wr, output full, empty, busy, ovf, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an input FIFO. Bytes written through the bus are
//   queued and serialized LSB first as 8N1 (8E1 when UART_TX_PARITY_EN is
//   defined) at CLK_FREQ/BAUD clocks per bit. Back-to-back frames have no
//   idle gap between them.
// Parameters
//   CLK_FREQ    system clock in Hz
//   BAUD        line rate in bit/s, DIV = CLK_FREQ/BAUD must be >= 2
//   FIFO_DEPTH  FIFO entries, a power of 2 and >= 2
// Ports
//   clk   system clock, posedge
//   rst   asynchronous reset, active low
//   bus   uart_tx_fifo_if.slave (din, wr in; full, empty, busy, ovf, tx out)
// Optional feature
//   UART_TX_PARITY_EN  adds an even parity bit after the data bits (8E1)
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;

  // Serializer
  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
  logic             w_par_next;
`endif

  state_t           w_state_next;
  logic [CNT_W-1:0] w_baud_next;
  logic [2:0]       w_bit_next;
  logic [7:0]       w_shift_next;
  logic             w_tx_next;
  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_head;
  logic [CW-1:0]    w_count_next;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_push = bus.wr & ~r_full;
  assign w_head = r_mem[r_rptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
      if (bus.wr && r_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  // tx is registered: each branch sets the level for the bit that begins at
  // this edge, so the line changes exactly on the state change.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
`ifdef UART_TX_PARITY_EN
          w_par_next   = ^w_head;
`endif
          w_state_next = S_START;
          w_baud_next  = BAUD_RELOAD;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (r_baud == '0) begin
          w_state_next = S_DATA;
          w_baud_next  = BAUD_RELOAD;
          w_bit_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      S_DATA: begin
        if (r_baud == '0) begin
          w_baud_next = BAUD_RELOAD;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_par;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];  // next bit after the shift
          end
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (r_baud == '0) begin
          w_state_next = S_STOP;
          w_baud_next  = BAUD_RELOAD;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (r_baud == '0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!r_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
`ifdef UART_TX_PARITY_EN
            w_par_next   = ^w_head;
`endif
            w_state_next = S_START;
            w_baud_next  = BAUD_RELOAD;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign bus.tx    = r_tx;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.full  = r_full;
  assign bus.empty = r_empty;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME    = 11 * DIV;
`else
  localparam int FRAME    = 10 * DIV;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int busy_total = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: a byte queue plus "which cycle of which frame".
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_can_push;

  logic cap_tx    [0:599];
  logic cap_empty [0:599];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      m_can_push = bus.wr && (q.size() < DEPTH);
      if (bus.wr && q.size() == DEPTH) m_ovf = 1'b1;
      if (m_active && m_pos < FRAME - 1) begin
        m_pos++;
      end else if (q.size() > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_active = 1'b0;
        m_pos    = 0;
      end
      if (m_can_push) q.push_back(bus.din);
    end
  end

  always @(negedge clk) begin
    if (bus.busy) busy_total++;
    if (cmp_en) begin
      chk("tx",    {31'd0, bus.tx},    {31'd0, exp_tx()});
      chk("busy",  {31'd0, bus.busy},  {31'd0, m_active});
      chk("full",  {31'd0, bus.full},  {31'd0, (q.size() == DEPTH)});
      chk("empty", {31'd0, bus.empty}, {31'd0, (q.size() == 0)});
      chk("ovf",   {31'd0, bus.ovf},   {31'd0, m_ovf});
    end
  end

  task automatic wr_byte(input logic [7:0] b);
    bus.wr  = 1'b1;
    bus.din = b;
    @(negedge clk);
    bus.wr  = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]    = bus.tx;
      cap_empty[i] = bus.empty;
    end
  endtask

  task automatic drain(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!bus.busy && bus.empty) break;
    end
    if (i == lim) chk("drain_timeout", 32'd1, 32'd0);
    $display("drain done after %0d cycles", i);
  endtask

  task automatic send_frame(input logic [7:0] b, input string tag);
    int b0;
    b0 = busy_total;
    wr_byte(b);
    capture(FRAME + 20);
    chk({tag, "_start"}, {31'd0, cap_tx[5]},  32'd0);
    chk({tag, "_bit0"},  {31'd0, cap_tx[15]}, {31'd0, b[0]});
    chk({tag, "_bit7"},  {31'd0, cap_tx[85]}, {31'd0, b[7]});
`ifdef UART_TX_PARITY_EN
    chk({tag, "_par"},   {31'd0, cap_tx[95]}, {31'd0, ^b});
`endif
    chk({tag, "_stop"},  {31'd0, cap_tx[FRAME-5]}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_total - b0, FRAME);
    $display("frame %s byte=%02h busy=%0d", tag, b, busy_total - b0);
  endtask

  initial begin
    int b0;
    int i;
    int dens;
    bus.wr  = 1'b0;
    bus.din = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, bus.tx},    32'd1);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_full",  {31'd0, bus.full},  32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_ovf",   {31'd0, bus.ovf},   32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0x55, pinned by hand
    send_frame(8'h55, "f55");
    chk("f55_bit1", {31'd0, cap_tx[25]}, 32'd0);
    chk("f55_bit2", {31'd0, cap_tx[35]}, 32'd1);

    // "H","i" back to back
    b0 = busy_total;
    bus.wr = 1'b1; bus.din = 8'h48;
    @(negedge clk);
    bus.din = 8'h69;
    @(negedge clk);
    bus.wr = 1'b0;
    capture(2 * FRAME + 20);
    chk("hi_stop_before_gap", {31'd0, cap_tx[FRAME-2]}, 32'd1);
    chk("hi_start_no_gap",    {31'd0, cap_tx[FRAME-1]}, 32'd0);
    chk("hi_empty_before_pop", {31'd0, cap_empty[FRAME-2]}, 32'd0);
    chk("hi_empty_after_pop",  {31'd0, cap_empty[FRAME-1]}, 32'd1);
    chk("hi_busy_cycles", busy_total - b0, 2 * FRAME);
    $display("burst Hi busy=%0d", busy_total - b0);

    // 01..06 burst: 01 popped, 02..05 fill, 06 dropped
    b0 = busy_total;
    bus.wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.din = 8'(k);
      @(negedge clk);
    end
    bus.wr = 1'b0;
    chk("burst_full", {31'd0, bus.full}, 32'd1);
    chk("burst_ovf",  {31'd0, bus.ovf},  32'd1);
    drain(6 * FRAME);
    chk("burst_busy_cycles", busy_total - b0, 5 * FRAME);
    $display("burst 01..06 busy=%0d ovf=%0b", busy_total - b0, bus.ovf);

    // Asynchronous reset in the middle of the data bits of 0xA3
    wr_byte(8'hA3);
    repeat (35) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx",    {31'd0, bus.tx},    32'd1);
    chk("arst_busy",  {31'd0, bus.busy},  32'd0);
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_ovf",   {31'd0, bus.ovf},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    b0 = busy_total;
    repeat (30) @(negedge clk);
    chk("arst_stays_idle", busy_total - b0, 32'd0);
    $display("async reset mid-frame done");

    // Write while full on the same edge as a pop
    bus.wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.din = 8'h10 + 8'(k);
      @(negedge clk);
    end
    bus.wr = 1'b0;
    chk("fp_full_before", {31'd0, bus.full}, 32'd1);
    chk("fp_ovf_before",  {31'd0, bus.ovf},  32'd0);
    for (i = 0; i < 3 * FRAME; i++) begin
      if (m_active && m_pos == FRAME - 1 && bus.full) break;
      @(negedge clk);
    end
    if (i == 3 * FRAME) chk("fp_wait_timeout", 32'd1, 32'd0);
    wr_byte(8'hEE);
    chk("fp_full_after", {31'd0, bus.full},  32'd0);
    chk("fp_ovf_after",  {31'd0, bus.ovf},   32'd1);
    chk("fp_busy_after", {31'd0, bus.busy},  32'd1);
    drain(6 * FRAME);
    $display("write-while-full with pop done");

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, "p07");
    chk("p07_parity_lit", {31'd0, cap_tx[95]}, 32'd1);
    send_frame(8'h03, "p03");
    chk("p03_parity_lit", {31'd0, cap_tx[95]}, 32'd0);
`endif

    // Randomized traffic at varying write density
    for (int ph = 0; ph < 8; ph++) begin
      dens = $urandom_range(0, 12);
      for (int c = 0; c < 500; c++) begin
        bus.wr  = ($urandom_range(0, 99) < dens);
        bus.din = 8'($urandom);
        @(negedge clk);
      end
      bus.wr = 1'b0;
      $display("random phase %0d density=%0d ovf=%0b", ph, dens, bus.ovf);
    end
    bus.wr = 1'b0;
    drain((DEPTH + 2) * FRAME);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit end of the UART link. Consumes the byte/strobe pair produced by the I/O controller (dout/rd style) and serializes it as 8N1 on the tx pin.
- Contains a small FIFO, so the controller can issue bursts (e.g. a 15-byte message) without waiting on the line rate.
- Sits between the I/O controller and the board TX pin. Runs from the single 100 MHz system clock.

Parameters:
- CLK_FREQ, 100000000: system clock frequency, Hz.
- BAUD, 115200: line rate, bit/s. DIV = CLK_FREQ/BAUD, integer-truncated. DIV must be >= 2.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- din  in  8  byte to transmit.
- wr  in  1  write strobe; din accepted on any posedge where wr=1 and full=0.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- busy  out  1  serializer state is not IDLE.
- ovf  out  1  sticky: a write was attempted while full.
- tx  out  1  serial line; idle high.

Behaviour:
- Reset (rst=0, asynchronous), regardless of activity:
  - tx=1, busy=0, full=0, empty=1, ovf=0.
  - FIFO pointers and count cleared; state=IDLE; baud and bit counters cleared.
  - A frame in progress is abandoned; the line returns high immediately.
- FIFO:
  - count is log2(FIFO_DEPTH)+1 bits; write and read pointers wrap modulo FIFO_DEPTH.
  - full/empty are registered, derived from count.
  - Push and pop on the same edge with 0 < count < FIFO_DEPTH: count unchanged, both pointers advance.
  - wr while full: byte dropped and ovf set to 1. This holds even if a pop occurs on the same edge.
  - ovf clears only on reset.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: if empty=0, pop the head byte into an 8-bit shift register, go to START, load baud counter with DIV-1. tx=1 while in IDLE.
  - START: tx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At the end of STOP, go directly to START with a new pop if the FIFO is non-empty, else go to IDLE.
  - Back-to-back frames have no idle gap: each frame is exactly 10*DIV cycles.
  - The baud counter counts down from DIV-1 and reloads at 0; a bit boundary occurs at count 0.
- Latency: wr accepted at edge N into an empty FIFO with state IDLE:
  - empty=0 after edge N.
  - Pop and START entry at edge N+1; tx falls at edge N+1.
  - busy=1 from edge N+1. busy falls at the edge the FSM returns to IDLE.
- tx is driven from a register, so it is glitch-free.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - tx = even parity, i.e. XOR of the 8 data bits.
  - Frame becomes 8E1, 11*DIV cycles.
- Undefined: no PARITY state; 8N1 framing, 10*DIV cycles, exactly as above.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so DIV=10; FIFO_DEPTH=4):
- Reset, then wr one cycle with din=8'h55 -> tx low at the next edge for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles. busy=1 for exactly 100 cycles.
- Write "H","i" on consecutive cycles -> two frames, 200 cycles total, no gap between stop bit and second start bit. empty=1 after the first pop of "i".
- Write 6 bytes 8'h01..8'h06 on consecutive cycles while the line is idle -> 8'h01 popped immediately, 8'h02..8'h05 fill the FIFO, full=1, 8'h06 dropped, ovf=1. Line carries 01..05 only.
- Pull rst low mid-DATA of 8'hA3 -> tx=1, busy=0, empty=1 with no clock edge. After release the line stays idle until the next wr.
- Write with full=1 on the same edge as a pop -> byte dropped, ovf=1, count goes FIFO_DEPTH-1.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit=1, frame is 110 cycles. Send 8'h03 -> parity bit=0.
